// File: rtl/croc_pkg.sv
// Shared croc types used by the OBI-to-regbus bridge and other fabric blocks.
// Also holds the bridge's default abort data and a counter-width helper.
package croc_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  aid;
    logic        a_optional;
    logic        req;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [2:0]  rid;
    logic        err;
    logic        r_optional;
    logic        gnt;
    logic        rvalid;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  localparam logic [31:0] RegBridgeErrRdata = 32'hBADCAB1E;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/croc_obi_reg_bridge.sv
// OBI subordinate -> regbus manager bridge, one transaction in flight.
// Define CROC_REG_BRIDGE_TIMEOUT_EN to abort regbus accesses after TimeoutCycles.
module croc_obi_reg_bridge
  import croc_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 255,
  parameter logic [31:0] ErrRdata      = RegBridgeErrRdata
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  sbr_obi_req_t obi_req_i,
  output sbr_obi_rsp_t obi_rsp_o,
  output reg_req_t     reg_req_o,
  input  reg_rsp_t     reg_rsp_i
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReg  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]  state_q;
  logic        active_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  aid_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic gnt;
  logic accept;
  logic timeout;

  // active_q keeps gnt low in the cycle right after reset so every output reads 0.
  assign gnt    = active_q && (state_q != StReg);
  assign accept = obi_req_i.req && gnt;

`ifdef CROC_REG_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = idx_width(TimeoutCycles);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == StReg && !reg_rsp_i.ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A ready arriving in the expiry cycle takes priority over the abort.
  assign timeout = (state_q == StReg) && !reg_rsp_i.ready &&
                   (cnt_q == CntW'(TimeoutCycles - 1));
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = ErrRdata ^ 32'(TimeoutCycles);
  assign timeout            = 1'b0;
`endif

  logic unused_a_optional;
  assign unused_a_optional = obi_req_i.a_optional;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      active_q <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      aid_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      active_q <= 1'b1;
      case (state_q)
        StReg: begin
          if (reg_rsp_i.ready) begin
            rdata_q <= we_q ? 32'h0 : reg_rsp_i.rdata;
            err_q   <= reg_rsp_i.error;
            state_q <= StResp;
          end else if (timeout) begin
            rdata_q <= ErrRdata;
            err_q   <= 1'b1;
            state_q <= StResp;
          end
        end
        default: state_q <= StIdle;
      endcase
      // Acceptance is only possible in IDLE/RESP, so it overrides the return to IDLE.
      if (accept) begin
        addr_q  <= obi_req_i.addr;
        we_q    <= obi_req_i.we;
        be_q    <= obi_req_i.be;
        wdata_q <= obi_req_i.wdata;
        aid_q   <= obi_req_i.aid;
        state_q <= StReg;
      end
    end
  end

  // NOTE: whole-struct defaults first so no field is left unassigned on any path,
  // which would otherwise infer a latch.
  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = gnt;
    obi_rsp_o.rvalid = (state_q == StResp);
    obi_rsp_o.rid    = aid_q;
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.err    = err_q;

    reg_req_o        = '0;
    reg_req_o.valid  = (state_q == StReg);
    reg_req_o.addr   = addr_q;
    reg_req_o.write  = we_q;
    reg_req_o.wdata  = wdata_q;
    reg_req_o.wstrb  = we_q ? be_q : 4'h0;
  end

endmodule

// File: tb/tb_croc_obi_reg_bridge.sv
// Randomized bench for croc_obi_reg_bridge against a transaction-level model.
// Build with CROC_REG_BRIDGE_TIMEOUT_EN to exercise the timeout abort.
module tb_croc_obi_reg_bridge;
  import croc_pkg::*;

  localparam int unsigned TO  = 8;
  localparam logic [31:0] ERR = 32'hBADCAB1E;
`ifdef CROC_REG_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  aid;
  } txn_t;

  typedef struct {
    int          delay;
    logic [31:0] rdata;
    logic        err;
  } plan_t;

  logic         clk_i  = 1'b0;
  logic         rst_ni = 1'b0;
  sbr_obi_req_t obi_req;
  sbr_obi_rsp_t obi_rsp;
  reg_req_t     reg_req;
  reg_rsp_t     reg_rsp;

  croc_obi_reg_bridge #(
    .TimeoutCycles(TO),
    .ErrRdata     (ERR)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .obi_req_i(obi_req),
    .obi_rsp_o(obi_rsp),
    .reg_req_o(reg_req),
    .reg_rsp_i(reg_rsp)
  );

  always #5 clk_i = ~clk_i;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: one access in flight; a response is due the cycle after it completes.
  txn_t        stim_q[$];
  plan_t       plan_q[$];
  bit          in_init   = 1'b1;
  bit          pending   = 1'b0;
  bit          ret_due   = 1'b0;
  bit          mreq      = 1'b0;
  bit          reset_req = 1'b0;
  txn_t        mtx;
  txn_t        cur;
  plan_t       plan;
  int          waited    = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err   = 1'b0;
  int unsigned req_pct   = 0;
  int unsigned stray_pct = 0;
  int          n_acc = 0, n_drop = 0, n_rv = 0;

  function automatic txn_t rand_txn();
    txn_t t;
    t.addr  = $urandom;
    t.we    = 1'($urandom_range(1));
    t.be    = 4'($urandom);
    t.wdata = $urandom;
    t.aid   = 3'($urandom);
    return t;
  endfunction

  function automatic txn_t mk_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                                  input logic [31:0] wdata, input logic [2:0] aid);
    txn_t t;
    t.addr = addr; t.we = we; t.be = be; t.wdata = wdata; t.aid = aid;
    return t;
  endfunction

  function automatic plan_t mk_plan(input int delay, input logic [31:0] rdata, input logic err);
    plan_t p;
    p.delay = delay; p.rdata = rdata; p.err = err;
    return p;
  endfunction

  task automatic step();
    sbr_obi_rsp_t rsp;
    reg_req_t     rq;
    txn_t         drv;
    bit           gnt_exp;
    bit           ready;
    logic [31:0]  rd;
    logic         er;

    @(negedge clk_i);
    rsp     = obi_rsp;
    rq      = reg_req;
    gnt_exp = !in_init && (!pending || ret_due);
    if (rsp.rvalid) n_rv++;

    if (in_init) begin
      check("reset_obi_rsp", 80'(rsp), 80'(0));
      check("reset_reg_req", 80'(rq), 80'(0));
    end
    check("gnt", 80'(rsp.gnt), 80'(gnt_exp));
    check("rvalid", 80'(rsp.rvalid), 80'(ret_due));
    check("valid", 80'(rq.valid), 80'(pending && !ret_due));
    check("r_optional", 80'(rsp.r_optional), 80'(0));
    if (ret_due) begin
      check("rid", 80'(rsp.rid), 80'(cur.aid));
      check("rdata", 80'(rsp.rdata), 80'(exp_rdata));
      check("err", 80'(rsp.err), 80'(exp_err));
    end
    if (pending && !ret_due) begin
      check("reg_addr", 80'(rq.addr), 80'(cur.addr));
      check("reg_write", 80'(rq.write), 80'(cur.we));
      check("reg_wdata", 80'(rq.wdata), 80'(cur.wdata));
      check("reg_wstrb", 80'(rq.wstrb), 80'(cur.we ? cur.be : 4'h0));
    end

    if (reset_req) begin
      rst_ni  = 1'b0;
      obi_req = '0;
      reg_rsp = '0;
      if (pending) n_drop++;
      pending = 1'b0;
      ret_due = 1'b0;
      mreq    = 1'b0;
      in_init = 1'b1;
      return;
    end
    rst_ni = 1'b1;

    if (!mreq) begin
      if (stim_q.size() != 0) begin
        mtx  = stim_q.pop_front();
        mreq = 1'b1;
      end else if ($urandom_range(99) < req_pct) begin
        mtx  = rand_txn();
        mreq = 1'b1;
      end
    end
    drv                = mreq ? mtx : rand_txn();
    obi_req.req        = mreq;
    obi_req.addr       = drv.addr;
    obi_req.we         = drv.we;
    obi_req.be         = drv.be;
    obi_req.wdata      = drv.wdata;
    obi_req.aid        = drv.aid;
    obi_req.a_optional = 1'($urandom_range(1));

    rd = $urandom;
    er = ($urandom_range(7) == 0);
    if (pending && !ret_due) begin
      ready = (waited >= plan.delay);
      if (ready) begin
        rd = plan.rdata;
        er = plan.err;
      end
    end else begin
      ready = ($urandom_range(99) < stray_pct);
    end
    reg_rsp = '{rdata: rd, error: er, ready: ready};

    if (ret_due) begin
      ret_due = 1'b0;
      pending = 1'b0;
    end else if (pending) begin
      if (ready) begin
        ret_due   = 1'b1;
        exp_rdata = cur.we ? 32'h0 : rd;
        exp_err   = er;
      end else if (TO_EN && waited == int'(TO) - 1) begin
        ret_due   = 1'b1;
        exp_rdata = ERR;
        exp_err   = 1'b1;
      end else begin
        waited++;
      end
    end
    if (gnt_exp && mreq) begin
      pending = 1'b1;
      cur     = mtx;
      waited  = 0;
      mreq    = 1'b0;
      n_acc++;
      if (plan_q.size() != 0) plan = plan_q.pop_front();
      else plan = mk_plan($urandom_range(0, 4), $urandom, $urandom_range(7) == 0);
    end
    in_init = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    obi_req = '0;
    reg_rsp = '0;

    reset_req = 1'b1;
    run(3);
    reset_req = 1'b0;

    // Single read, ready one cycle after valid.
    stim_q.push_back(mk_txn(32'h0300_0004, 1'b0, 4'hF, 32'h0, 3'd5));
    plan_q.push_back(mk_plan(1, 32'h1234_5678, 1'b0));
    run(8);

    // Write with 3-cycle stall; read data from regbus must not leak through.
    stim_q.push_back(mk_txn(32'h0300_0010, 1'b1, 4'b0011, 32'hCAFE_F00D, 3'd2));
    plan_q.push_back(mk_plan(3, 32'hFFFF_FFFF, 1'b0));
    run(10);

    // Back-to-back reads with immediate ready.
    for (int i = 0; i < 4; i++) begin
      stim_q.push_back(mk_txn(32'h0300_0100 + 32'(4 * i), 1'b0, 4'hF, 32'h0, 3'(i)));
      plan_q.push_back(mk_plan(0, 32'hA000_0000 + 32'(i), 1'b0));
    end
    run(12);

    // Regbus error.
    stim_q.push_back(mk_txn(32'h0300_0020, 1'b0, 4'hF, 32'h0, 3'd6));
    plan_q.push_back(mk_plan(0, 32'h5555_AAAA, 1'b1));
    run(6);

    // Long stall: aborts at TO with the macro, otherwise waits past 100 cycles.
    // Stray ready is held high whenever the regbus is not being waited on.
    stray_pct = 100;
    stim_q.push_back(mk_txn(32'h0300_0030, 1'b0, 4'hF, 32'h0, 3'd7));
    plan_q.push_back(mk_plan(120, 32'h0BAD_F00D, 1'b0));
    run(130);
    stray_pct = 0;

    // Reset while waiting on the regbus, then a fresh read.
    stim_q.push_back(mk_txn(32'h0300_0040, 1'b0, 4'hF, 32'h0, 3'd1));
    plan_q.push_back(mk_plan(20, 32'h0, 1'b0));
    run(3);
    reset_req = 1'b1;
    step();
    reset_req = 1'b0;
    step();
    stim_q.push_back(mk_txn(32'h0300_0044, 1'b0, 4'hF, 32'h0, 3'd3));
    plan_q.push_back(mk_plan(1, 32'h7777_0001, 1'b0));
    run(8);

    // Random traffic with stray ready pulses.
    req_pct   = 60;
    stray_pct = 25;
    run(3000);

    req_pct = 0;
    for (int i = 0; i < 300 && (pending || mreq); i++) step();
    step();
    check("drained", 80'(pending || mreq), 80'(0));
    check("response_count", 80'(n_rv), 80'(n_acc - n_drop));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
